arm_alu_seq: RTL

- Parametrised, multi-cycle successor to the single-cycle ARM-mode ALU. Operand width is generic.
- The combinational array multiplier is replaced by an iterative shift-add engine that processes one multiplier bit per cycle.
- Adds registered result and flags, plus a start/busy/done handshake.
- Sits between the register-file read ports and the write-back mux. The control FSM launches an operation and waits for done before asserting register write enable.

---
 rtl/arm_alu_pkg.sv | 32 +++
 rtl/arm_alu_mul_iter.sv | 74 +++++++
 rtl/arm_alu_seq.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/arm_alu_pkg.sv
// -----------------------------------------------------------------------------
// arm_alu_pkg
// Shared definitions for the multi-cycle ARM-mode ALU (arm_alu_seq):
//   - opcode encodings (3-bit, fixed)
//   - control FSM state encoding
//   - bit positions of {N,Z,C,V} inside the 4-bit flags word
// -----------------------------------------------------------------------------
package arm_alu_pkg;

    localparam int OP_BITS = 3;

    localparam logic [OP_BITS-1:0] OP_ADD  = 3'b000;
    localparam logic [OP_BITS-1:0] OP_SUB  = 3'b001;
    localparam logic [OP_BITS-1:0] OP_MOV  = 3'b010;
    localparam logic [OP_BITS-1:0] OP_LSR  = 3'b011;
    localparam logic [OP_BITS-1:0] OP_DEC  = 3'b100;
    localparam logic [OP_BITS-1:0] OP_MUL  = 3'b101;
    localparam logic [OP_BITS-1:0] OP_PASS = 3'b110;  // 3'b111 also passes rd

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_MUL  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/arm_alu_mul_iter.sv
// -----------------------------------------------------------------------------
// arm_alu_mul_iter
// Iterative shift-add multiplier, one multiplier bit per step. Keeps only the
// low WIDTH bits of the product.
//
// Ports:
//   clk, rst_n     clock / asynchronous active-low reset
//   load           capture operands, clear accumulator and counter
//   step           perform one iteration this cycle
//   multiplicand   operand shifted left each step
//   multiplier     operand shifted right each step; its LSB gates the add
//   product        accumulator value *after* the iteration in progress, so the
//                  parent can register it on the same edge that ends the op
//   last           the iteration in progress is the final one
//
// Build option: ARM_ALU_MUL_EARLY_EXIT_EN -- when defined, 'last' also fires
// once the remaining multiplier bits are all zero (result is unchanged).
// -----------------------------------------------------------------------------
module arm_alu_mul_iter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] multiplicand,
    input  logic [WIDTH-1:0] multiplier,
    output logic [WIDTH-1:0] product,
    output logic             last
);

    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [WIDTH-1:0] r_acc;
    logic [CW-1:0]    r_cnt;

    logic [WIDTH-1:0] w_addend;
    logic             w_cnt_last;

    assign w_addend   = r_mplier[0] ? r_mcand : '0;
    assign product    = r_acc + w_addend;
    assign w_cnt_last = (r_cnt == CW'(WIDTH - 1));

`ifdef ARM_ALU_MUL_EARLY_EXIT_EN
    // Bits above the one consumed now are all zero: further steps add nothing.
    assign last = w_cnt_last || (r_mplier[WIDTH-1:1] == '0);
`else
    assign last = w_cnt_last;
`endif

    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
        end else if (load) begin
            r_mcand  <= multiplicand;
            r_mplier <= multiplier;
            r_acc    <= '0;
            r_cnt    <= '0;
        end else if (step) begin
            r_acc    <= product;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/arm_alu_seq.sv
// -----------------------------------------------------------------------------
// arm_alu_seq
// Multi-cycle ARM-mode ALU with registered result/flags and a start/busy/done
// handshake. Single-cycle ops go IDLE->EXEC->DONE; mul goes IDLE->MUL(xN)->DONE
// using arm_alu_mul_iter.
//
// Ports:
//   clk, rst_n   clock / asynchronous active-low reset
//   start        request, sampled only in IDLE
//   op           000 add, 001 sub, 010 mov, 011 lsr, 100 dec, 101 mul,
//                110/111 pass rd
//   cin          carry-in for mov
//   rd_data      operand A (multiplier for mul)
//   rs_data      operand B (multiplicand for mul)
//   result       registered result, held until the next done
//   flags        registered {N,Z,C,V}
//   busy         high while an operation is executing (not in DONE)
//   done         one-cycle pulse; result/flags valid in that cycle
//
// Build option: ARM_ALU_MUL_EARLY_EXIT_EN (see arm_alu_mul_iter); affects mul
// latency only. WIDTH must be at least 4.
// -----------------------------------------------------------------------------
module arm_alu_seq
    import arm_alu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int OPW   = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [OPW-1:0]   op,
    input  logic             cin,
    input  logic [WIDTH-1:0] rd_data,
    input  logic [WIDTH-1:0] rs_data,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags,
    output logic             busy,
    output logic             done
);

    localparam int XW = WIDTH + 1;

    state_t           r_state;
    state_t           w_state_next;

    logic [OPW-1:0]   r_op;
    logic             r_cin;
    logic [WIDTH-1:0] r_rd;
    logic [WIDTH-1:0] r_rs;
    logic [WIDTH-1:0] r_result;
    logic [3:0]       r_flags;

    logic             w_accept;
    logic             w_capture;
    logic [WIDTH-1:0] w_product;
    logic             w_mul_last;

    logic [XW-1:0]    w_ext;
    logic [WIDTH-1:0] w_res;
    logic             w_c;
    logic             w_v;

    assign w_accept  = (r_state == ST_IDLE) && start;
    assign w_capture = (r_state == ST_EXEC) || ((r_state == ST_MUL) && w_mul_last);

    arm_alu_mul_iter #(
        .WIDTH(WIDTH)
    ) u_mul (
        .clk          (clk),
        .rst_n        (rst_n),
        .load         (w_accept && (op == OP_MUL)),
        .step         (r_state == ST_MUL),
        .multiplicand (rs_data),
        .multiplier   (rd_data),
        .product      (w_product),
        .last         (w_mul_last)
    );

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // NOTE: every always_comb output gets a default before the case, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_state_next = r_state;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_next = (op == OP_MUL) ? ST_MUL : ST_EXEC;
                end
            end
            ST_EXEC: begin
                busy         = 1'b1;
                w_state_next = ST_DONE;
            end
            ST_MUL: begin
                busy = 1'b1;
                if (w_mul_last) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                done         = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // ---------------- Operand capture ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op  <= '0;
            r_cin <= 1'b0;
            r_rd  <= '0;
            r_rs  <= '0;
        end else if (w_accept) begin
            r_op  <= op;
            r_cin <= cin;
            r_rd  <= rd_data;
            r_rs  <= rs_data;
        end
    end

    // ---------------- Datapath (WIDTH+1 bit, carry in the top bit) ----------------
    always_comb begin
        w_ext = '0;
        w_res = r_rd;
        w_c   = 1'b0;
        w_v   = 1'b0;
        case (r_op)
            OP_ADD: begin
                w_ext = {1'b0, r_rd} + {1'b0, r_rs};
                w_res = w_ext[WIDTH-1:0];
                w_c   = w_ext[WIDTH];
                w_v   = (r_rd[WIDTH-1] == r_rs[WIDTH-1]) && (w_ext[WIDTH-1] != r_rd[WIDTH-1]);
            end
            OP_SUB: begin
                // Two's-complement subtract; carry set means no borrow.
                w_ext = {1'b0, r_rd} + {1'b0, ~r_rs} + XW'(1);
                w_res = w_ext[WIDTH-1:0];
                w_c   = w_ext[WIDTH];
                w_v   = (r_rd[WIDTH-1] != r_rs[WIDTH-1]) && (w_ext[WIDTH-1] != r_rd[WIDTH-1]);
            end
            OP_MOV: begin
                w_ext = {1'b0, r_rs} + XW'(r_cin);
                w_res = w_ext[WIDTH-1:0];
                w_c   = w_ext[WIDTH];
            end
            OP_LSR: begin
                w_res = {1'b0, r_rs[WIDTH-1:1]};
                w_c   = r_rs[0];
            end
            OP_DEC: begin
                // Adding all-ones carries out for every rs except zero.
                w_ext = {1'b0, r_rs} + {1'b0, {WIDTH{1'b1}}};
                w_res = w_ext[WIDTH-1:0];
                w_c   = w_ext[WIDTH];
            end
            OP_MUL: begin
                w_res = w_product;
            end
            default: begin
                w_res = r_rd;
            end
        endcase
    end

    // ---------------- Result / flags registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_result <= '0;
            r_flags  <= '0;
        end else if (w_capture) begin
            r_result        <= w_res;
            r_flags[FLAG_N] <= w_res[WIDTH-1];
            r_flags[FLAG_Z] <= (w_res == '0);
            r_flags[FLAG_C] <= w_c;
            r_flags[FLAG_V] <= w_v;
        end
    end

    assign result = r_result;
    assign flags  = r_flags;

endmodule
